// File: rtl/bank_cmd_issuer.sv
// Single-bank command issuer: turns one read/write request at a time into
// ACT / RD / WR / PR / REF command pulses while enforcing bank timing and
// periodic refresh.
//
// Ports
//   clk_i                     clock
//   rst_i                     synchronous active-high reset
//   req_valid_i / req_ready_o request handshake (accepted when both high)
//   req_write_i               1 = write, 0 = read
//   req_row_i / req_col_i     request row / column address
//   act_o rd_o wr_o pr_o ref_o  one-cycle command pulses (at most one high)
//   cmd_row_o                 row address, valid with act_o
//   cmd_col_o                 column address, valid with rd_o / wr_o
//   rd_done_o / wr_done_o     one-cycle pulse at the end of a read/write burst
module bank_cmd_issuer #(
  parameter int unsigned T_CL   = 17,
  parameter int unsigned T_CWL  = 10,
  parameter int unsigned T_RCD  = 17,
  parameter int unsigned T_RP   = 17,
  parameter int unsigned T_RFC  = 34,
  parameter int unsigned T_WR   = 14,
  parameter int unsigned T_RTP  = 7,
  parameter int unsigned BL     = 8,
  parameter int unsigned T_REFI = 1560
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [15:0] req_row_i,
  input  logic [9:0]  req_col_i,
  output logic        act_o,
  output logic        rd_o,
  output logic        wr_o,
  output logic        pr_o,
  output logic        ref_o,
  output logic [15:0] cmd_row_o,
  output logic [9:0]  cmd_col_o,
  output logic        rd_done_o,
  output logic        wr_done_o
);

  localparam int unsigned CW        = 8;
  localparam int unsigned RW        = 16;
  localparam int unsigned ROW_W     = 16;
  localparam int unsigned COL_W     = 10;
  localparam int unsigned RD_PR_GAP = (T_RTP > BL) ? T_RTP : BL;

  typedef enum logic [2:0] {
    S_IDLE, S_ACTWAIT, S_OPEN, S_RDBURST, S_WRBURST, S_PREWAIT, S_REFWAIT
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      pr_cnt_q, pr_cnt_d;
  logic [RW-1:0]      ref_cnt_q, ref_cnt_d;
  logic               ref_pend_q, ref_pend_d;
  logic               req_pend_q, req_pend_d;
  logic               data_q, data_d;
  logic               write_q, write_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ROW_W-1:0]   open_row_q, open_row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               ready_q, ready_d;
  logic               act_q, act_d, rd_q, rd_d, wr_q, wr_d, pr_q, pr_d, ref_q, ref_d;
  logic [ROW_W-1:0]   cmd_row_q, cmd_row_d;
  logic [COL_W-1:0]   cmd_col_q, cmd_col_d;
  logic               rd_done_q, rd_done_d, wr_done_q, wr_done_d;

  logic               accept_c, expire_c, cnt_last_c, pr_ok_c;
  logic               do_col_c, col_wr_c, do_ref_c;
  logic [COL_W-1:0]   col_sel_c;

  assign accept_c   = req_valid_i & ready_q;
  assign expire_c   = (ref_cnt_q == RW'(1));
  assign cnt_last_c = (cnt_q <= CW'(1));
  assign pr_ok_c    = (pr_cnt_q == CW'(0));

  // Next-state and command generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pr_cnt_d   = pr_ok_c ? pr_cnt_q : pr_cnt_q - CW'(1);
    ref_cnt_d  = expire_c ? RW'(T_REFI) : ref_cnt_q - RW'(1);
    ref_pend_d = ref_pend_q;
    req_pend_d = req_pend_q;
    data_d     = data_q;
    write_d    = write_q;
    row_d      = row_q;
    open_row_d = open_row_q;
    col_d      = col_q;
    act_d      = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    pr_d       = 1'b0;
    ref_d      = 1'b0;
    cmd_row_d  = cmd_row_q;
    cmd_col_d  = cmd_col_q;
    rd_done_d  = 1'b0;
    wr_done_d  = 1'b0;
    do_col_c   = 1'b0;
    col_wr_c   = 1'b0;
    col_sel_c  = col_q;
    do_ref_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          do_ref_c = 1'b1;
        end else if (accept_c) begin
          act_d      = 1'b1;
          cmd_row_d  = req_row_i;
          open_row_d = req_row_i;
          row_d      = req_row_i;
          col_d      = req_col_i;
          write_d    = req_write_i;
          cnt_d      = CW'(T_RCD);
          state_d    = S_ACTWAIT;
        end
      end
      S_ACTWAIT: begin
        if (cnt_last_c) begin
          do_col_c = 1'b1;
          col_wr_c = write_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_OPEN: begin
        // An accepted row miss or a pending refresh both need PR first.
        if (req_pend_q || ref_pend_q) begin
          if (pr_ok_c) begin
            pr_d    = 1'b1;
            cnt_d   = CW'(T_RP);
            state_d = S_PREWAIT;
          end
        end else if (accept_c) begin
          row_d   = req_row_i;
          col_d   = req_col_i;
          write_d = req_write_i;
          if (req_row_i == open_row_q) begin
            do_col_c  = 1'b1;
            col_wr_c  = req_write_i;
            col_sel_c = req_col_i;
          end else begin
            req_pend_d = 1'b1;
            if (pr_ok_c) begin
              pr_d    = 1'b1;
              cnt_d   = CW'(T_RP);
              state_d = S_PREWAIT;
            end
          end
        end
      end
      S_RDBURST, S_WRBURST: begin
        // Latency phase then data phase, each counted by cnt.
        if (cnt_last_c) begin
          if (!data_q) begin
            data_d = 1'b1;
            cnt_d  = CW'(BL);
          end else begin
            data_d  = 1'b0;
            state_d = S_OPEN;
            if (state_q == S_RDBURST) begin
              rd_done_d = 1'b1;
            end else begin
              wr_done_d = 1'b1;
              pr_cnt_d  = CW'(T_WR - 1);
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PREWAIT: begin
        if (cnt_last_c) begin
          if (req_pend_q) begin
            req_pend_d = 1'b0;
            act_d      = 1'b1;
            cmd_row_d  = row_q;
            open_row_d = row_q;
            cnt_d      = CW'(T_RCD);
            state_d    = S_ACTWAIT;
          end else begin
            do_ref_c = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_REFWAIT: begin
        if (cnt_last_c) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Column command issue shared by ACTWAIT and OPEN row hit.
    if (do_col_c) begin
      cmd_col_d = col_sel_c;
      data_d    = 1'b0;
      if (col_wr_c) begin
        wr_d    = 1'b1;
        cnt_d   = CW'(T_CWL);
        state_d = S_WRBURST;
      end else begin
        rd_d     = 1'b1;
        cnt_d    = CW'(T_CL);
        pr_cnt_d = CW'(RD_PR_GAP - 1);
        state_d  = S_RDBURST;
      end
    end

    // REF closes the bank; REFWAIT covers the rest of tRFC so ACT lands at REF+T_RFC.
    if (do_ref_c) begin
      ref_d      = 1'b1;
      ref_pend_d = 1'b0;
      cnt_d      = CW'(T_RFC - 1);
      state_d    = (T_RFC > 1) ? S_REFWAIT : S_IDLE;
    end

    if (expire_c) begin
      ref_pend_d = 1'b1;
    end

    // Drop ready one cycle ahead of expiry so refresh wins over a new request.
    ready_d = ((state_d == S_IDLE) || (state_d == S_OPEN)) && !ref_pend_d &&
              !req_pend_d && (ref_cnt_d != RW'(1));
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pr_cnt_q   <= '0;
      ref_cnt_q  <= RW'(T_REFI);
      ref_pend_q <= 1'b0;
      req_pend_q <= 1'b0;
      data_q     <= 1'b0;
      write_q    <= 1'b0;
      row_q      <= '0;
      open_row_q <= '0;
      col_q      <= '0;
      ready_q    <= 1'b0;
      act_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      pr_q       <= 1'b0;
      ref_q      <= 1'b0;
      cmd_row_q  <= '0;
      cmd_col_q  <= '0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pr_cnt_q   <= pr_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      req_pend_q <= req_pend_d;
      data_q     <= data_d;
      write_q    <= write_d;
      row_q      <= row_d;
      open_row_q <= open_row_d;
      col_q      <= col_d;
      ready_q    <= ready_d;
      act_q      <= act_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      pr_q       <= pr_d;
      ref_q      <= ref_d;
      cmd_row_q  <= cmd_row_d;
      cmd_col_q  <= cmd_col_d;
      rd_done_q  <= rd_done_d;
      wr_done_q  <= wr_done_d;
    end
  end

  assign req_ready_o = ready_q;
  assign act_o       = act_q;
  assign rd_o        = rd_q;
  assign wr_o        = wr_q;
  assign pr_o        = pr_q;
  assign ref_o       = ref_q;
  assign cmd_row_o   = cmd_row_q;
  assign cmd_col_o   = cmd_col_q;
  assign rd_done_o   = rd_done_q;
  assign wr_done_o   = wr_done_q;

endmodule
